// File: rtl/axi3_read_responder.sv
// AXI3 read-channel responder backed by a byte-addressed local memory.
// Ports: clock/reset, AR channel in, R channel out, side preload port (mem_*).
module axi3_read_responder #(
    parameter int DATAWIDTH = 32,
    parameter int SIZE      = 3,
    parameter int MEMBYTES  = 4096
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATAWIDTH-1:0]   ARaddr,
    input  logic [DATAWIDTH/8-1:0] ARid,
    input  logic [DATAWIDTH/8-1:0] ARlen,
    input  logic [SIZE-1:0]        ARsize,
    input  logic [SIZE-2:0]        ARburst,
    input  logic                   ARvalid,
    output logic                   ARready,
    output logic [DATAWIDTH-1:0]   RData,
    output logic [DATAWIDTH/8-1:0] RId,
    output logic [1:0]             RResp,
    output logic                   RLast,
    output logic                   RValid,
    input  logic                   RReady,
    input  logic                   mem_we,
    input  logic [11:0]            mem_waddr,
    input  logic [7:0]             mem_wdata
);

    localparam int LANES = DATAWIDTH / 8;
    localparam int LB    = $clog2(LANES);
    localparam int AW    = $clog2(MEMBYTES);

    typedef enum logic {IDLE, DATA} state_t;

    state_t state, state_n;

    logic [7:0]       mem [MEMBYTES];
    logic [AW-1:0]    addr_q, addr_n;
    logic [LANES-1:0] id_q;
    logic [LANES-1:0] len_q;
    logic [SIZE-1:0]  size_q;
    logic [SIZE-2:0]  burst_q;
    logic [LANES-1:0] beat_q;
    logic             err_q;

    logic             ar_hs, r_hs, last;
    logic             err_in;
    logic [AW-1:0]    sz_in, sz, total, lower, incr_a, wrap_a;
    logic [LB-1:0]    lo, cmask, endlane;
    logic [AW-1:0]    wbase;
    logic             unused_hi;

    assign unused_hi = ^ARaddr[DATAWIDTH-1:AW];

    assign ar_hs = ARvalid && ARready;
    assign r_hs  = RValid && RReady;
    assign last  = (beat_q == len_q);

    // Error classification is done once, on the AR inputs
    always_comb begin
        sz_in  = AW'(1) << ARsize;
        err_in = 1'b0;
        if (ARsize > SIZE'(LB))
            err_in = 1'b1;
        if (ARburst == 2'b11)
            err_in = 1'b1;
        if (ARburst == 2'b10) begin
            if (!(ARlen == 4'd1 || ARlen == 4'd3 ||
                  ARlen == 4'd7 || ARlen == 4'd15))
                err_in = 1'b1;
            if ((ARaddr[AW-1:0] & (sz_in - AW'(1))) != '0)
                err_in = 1'b1;
        end
    end

    // Next beat address, all arithmetic modulo MEMBYTES
    always_comb begin
        sz     = AW'(1) << size_q;
        incr_a = (addr_q & ~(sz - AW'(1))) + sz;
        total  = sz * (AW'(len_q) + AW'(1));
        lower  = addr_q & ~(total - AW'(1));
        wrap_a = addr_q + sz;
        if (wrap_a == lower + total)
            wrap_a = lower;
        unique case (burst_q)
            2'b01:   addr_n = incr_a;
            2'b10:   addr_n = wrap_a;
            default: addr_n = addr_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q  <= '0;
            id_q    <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else if (ar_hs) begin
            addr_q  <= ARaddr[AW-1:0];
            id_q    <= ARid;
            len_q   <= ARlen;
            size_q  <= ARsize;
            burst_q <= ARburst;
            beat_q  <= '0;
            err_q   <= err_in;
        end else if (r_hs && !last) begin
            addr_q <= addr_n;
            beat_q <= beat_q + 1'b1;
        end
    end

    // Preload port; a same-cycle read sees the pre-write byte
    always_ff @(posedge clock) begin
        if (mem_we)
            mem[mem_waddr[AW-1:0]] <= mem_wdata;
    end

    always_comb begin
        state_n = state;
        ARready = 1'b0;
        RValid  = 1'b0;
        RLast   = 1'b0;
        RId     = '0;
        RResp   = 2'b00;
        unique case (state)
            IDLE: begin
                ARready = 1'b1;
                if (ar_hs)
                    state_n = DATA;
            end
            DATA: begin
                RValid = 1'b1;
                RLast  = last;
                RId    = id_q;
                RResp  = err_q ? 2'b10 : 2'b00;
                if (r_hs && last)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Active lanes: from addr within the word up to the end of its
    // size-aligned container
    always_comb begin
        lo      = addr_q[LB-1:0];
        cmask   = LB'(sz) - LB'(1);
        endlane = (lo & ~cmask) | cmask;
        wbase   = addr_q & ~AW'(LANES - 1);
        RData   = '0;
        if (state == DATA && !err_q) begin
            for (int i = 0; i < LANES; i++) begin
                if (int'(lo) <= i && i <= int'(endlane))
                    RData[8*i +: 8] = mem[wbase + AW'(i)];
            end
        end
    end

endmodule
